fetch_unit: RTL and testbench

- Instruction fetch stage. Owns the 4-bit program counter and drives the address of the 16x16 combinational instruction memory.
- Registers each fetched word, together with its PC, into an output slot. The slot is handed to decode through a valid/ready handshake.
- Supports start/stop (run), redirect for branch/jump with flush, and halt on a designated opcode.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect request and the
// valid/ready output slot handed to decode.
interface fetch_unit_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-entry output slot with valid/ready,
// run/stop, redirect with flush, and halt on a designated opcode.
module fetch_unit #(
  parameter int         ADDR_W      = 4,
  parameter int         INSTR_W     = 16,
  parameter int         RESET_PC    = 0,
  parameter logic [3:0] HALT_OPCODE = 4'b1111,
  parameter int         CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  fetch_unit_if.master        bus,
  output logic                halted,
  output logic [CNT_W-1:0]    fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              slot_free, xfer, do_fetch, is_halt_op;

  assign bus.imem_addr = pc;
  assign halted        = (state == HALT);
  assign is_halt_op    = (bus.imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    slot_free = !bus.out_valid || bus.out_ready;
    xfer      = bus.out_valid && bus.out_ready;
    do_fetch  = 1'b0;
    case (state)
      IDLE: if (run && !bus.redirect_valid) state_nxt = FETCH;
      FETCH: begin
        do_fetch = slot_free && !bus.redirect_valid;
        // A captured halt word wins over run dropping in the same cycle
        if (do_fetch && is_halt_op) state_nxt = HALT;
        else if (!run)              state_nxt = IDLE;
      end
      HALT: if (bus.redirect_valid) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= ADDR_W'(RESET_PC);
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_pc    <= '0;
      fetch_count   <= '0;
    end else begin
      if (xfer) fetch_count <= fetch_count + CNT_W'(1);
      if (bus.redirect_valid) begin
        pc            <= bus.redirect_pc;
        bus.out_valid <= 1'b0;
      end else if (do_fetch) begin
        bus.out_instr <= bus.imem_instr;
        bus.out_pc    <= pc;
        bus.out_valid <= 1'b1;
        pc            <= pc + ADDR_W'(1);
      end else if (xfer) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the scenario.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst, run;
  logic       halted;
  logic [7:0] fetch_count;
  logic [15:0] mem [16];

  int errors = 0;
  int checks = 0;

  fetch_unit_if #(.ADDR_W(4), .INSTR_W(16)) bus ();

  fetch_unit dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign bus.imem_instr = mem[bus.imem_addr];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the output slot is a queue of at most one word
  typedef struct { int instr; int pc; } word_t;
  word_t m_q[$];
  int    m_pc = 0, m_cnt = 0;
  bit    m_running = 0, m_halted = 0, started = 0;

  always @(posedge clk) begin
    bit    xfer, fetch, was_run, was_halt;
    word_t w;
    started = 1;
    if (rst) begin
      m_pc = 0; m_cnt = 0; m_q.delete(); m_running = 0; m_halted = 0;
    end else begin
      was_run  = m_running;
      was_halt = m_halted;
      xfer  = (m_q.size() > 0) && bus.out_ready;
      fetch = was_run && ((m_q.size() == 0) || bus.out_ready) && !bus.redirect_valid;
      w.instr = 0; w.pc = 0;
      if (xfer) begin
        void'(m_q.pop_front());
        m_cnt = (m_cnt + 1) % 256;
      end
      if (bus.redirect_valid) begin
        m_q.delete();
        m_pc = int'(bus.redirect_pc);
      end else if (fetch) begin
        w.instr = int'(mem[m_pc]);
        w.pc    = m_pc;
        m_q.push_back(w);
        m_pc = (m_pc + 1) % 16;
      end
      if (was_halt) begin
        if (bus.redirect_valid) begin m_halted = 0; m_running = 1; end
      end else if (was_run) begin
        if (fetch && (w.instr / 4096) == 15) begin m_halted = 1; m_running = 0; end
        else if (!run) m_running = 0;
      end else if (run && !bus.redirect_valid) begin
        m_running = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model imem_addr", int'(bus.imem_addr), m_pc);
      chk("model out_valid", int'(bus.out_valid), int'(m_q.size() > 0));
      chk("model halted", int'(halted), int'(m_halted));
      chk("model fetch_count", int'(fetch_count), m_cnt);
      if (m_q.size() > 0) begin
        chk("model out_instr", int'(bus.out_instr), m_q[0].instr);
        chk("model out_pc", int'(bus.out_pc), m_q[0].pc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(string nm, int instr, int pc, int addr);
    chk({nm, " valid"}, int'(bus.out_valid), 1);
    chk({nm, " instr"}, int'(bus.out_instr), instr);
    chk({nm, " pc"}, int'(bus.out_pc), pc);
    chk({nm, " addr"}, int'(bus.imem_addr), addr);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'h6016; mem[1] = 16'h0024; mem[2] = 16'h6045; mem[3] = 16'hF000;
    rst = 1'b1; run = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;
    repeat (2) step();
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset imem_addr", int'(bus.imem_addr), 0);
    chk("reset fetch_count", int'(fetch_count), 0);
    chk("reset halted", int'(halted), 0);
    rst = 1'b0; run = 1'b1;

    // Straight-line fetch with a 3-cycle stall on the second word
    step(); chk("idle->fetch addr", int'(bus.imem_addr), 0);
    chk("idle->fetch valid", int'(bus.out_valid), 0);
    step(); chk_out("w0", 'h6016, 0, 1);
    step(); chk_out("w1", 'h0024, 1, 2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stall w1", 'h0024, 1, 2);
    end
    bus.out_ready = 1'b1;
    step(); chk_out("w2", 'h6045, 2, 3);
    step(); chk_out("w3 halt", 'hF000, 3, 4);
    chk("halted set", int'(halted), 1);
    step(); chk("drain valid", int'(bus.out_valid), 0);
    chk("count 4", int'(fetch_count), 4);
    repeat (2) step();
    chk("halt addr held", int'(bus.imem_addr), 4);
    chk("halt stays", int'(halted), 1);

    // Exit halt to PC 1, then flush that slot with a redirect to PC 2
    bus.redirect_valid = 1'b1; bus.redirect_pc = 4'd1;
    step(); bus.redirect_valid = 1'b0;
    chk("redir halted clr", int'(halted), 0);
    chk("redir addr", int'(bus.imem_addr), 1);
    step(); chk_out("refetch w1", 'h0024, 1, 2);
    bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 4'd2;
    step(); chk("flush valid", int'(bus.out_valid), 0);
    chk("flush addr", int'(bus.imem_addr), 2);
    chk("flush count", int'(fetch_count), 4);
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    step(); chk_out("after redir", 'h6045, 2, 3);
    step(); chk("halt again", int'(halted), 1);
    step(); chk("count 6", int'(fetch_count), 6);

    // Wrap: redirect to 15 fetches 15 then 0
    bus.redirect_valid = 1'b1; bus.redirect_pc = 4'd15;
    step(); bus.redirect_valid = 1'b0;
    chk("wrap halted clr", int'(halted), 0);
    chk("wrap addr", int'(bus.imem_addr), 15);
    step(); chk_out("w15", 'h0000, 15, 0);
    step(); chk_out("wrap w0", 'h6016, 0, 1);

    // Stop with a pending stalled slot; it drains, nothing new is fetched
    bus.out_ready = 1'b0; run = 1'b0;
    step(); chk_out("stop hold", 'h6016, 0, 1);
    bus.out_ready = 1'b1;
    step(); chk("stop drained", int'(bus.out_valid), 0);
    chk("stop pc", int'(bus.imem_addr), 1);
    chk("count 8", int'(fetch_count), 8);
    step(); chk("stop idle", int'(bus.out_valid), 0);

    // Reset in mid-stream
    run = 1'b1;
    step(); step(); chk_out("pre-rst w1", 'h0024, 1, 2);
    rst = 1'b1;
    step(); chk("rst valid", int'(bus.out_valid), 0);
    chk("rst addr", int'(bus.imem_addr), 0);
    chk("rst count", int'(fetch_count), 0);
    rst = 1'b0; run = 1'b0;
    repeat (3) step();
    chk("rst idle valid", int'(bus.out_valid), 0);
    chk("rst idle addr", int'(bus.imem_addr), 0);
    run = 1'b1;
    repeat (3) step();
    chk_out("restart w1", 'h0024, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
